aes128_iter_ctrl: RTL and testbench

Iterative AES-128 encryption controller. It accepts one 128-bit plaintext and one 128-bit cipher key per transaction and performs the initial AddRoundKey. It then sequences one instance of `aesround` for 10 cycles, generating each round key on the fly, and holds the ciphertext until the consumer accepts it. This block sits between the host-side block interface and the `aesround` datapath, and it is the only driver of that datapath's `round_in`, `key_words` and `fin_counter_in`.

---
 rtl/aes128_iter_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_aes128_iter_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: one aesround instance driven for 10 cycles with on-the-fly key expansion.
// Latency: 10 cycles from the accept edge to out_valid; minimum initiation interval 12 cycles.
// Backpressure: in_ready only in IDLE; ct_out and all registers freeze in DONE until out_ready.
//
// Ports: eph1 (clock), reset (async, active-high), in_valid/in_ready/pt_in/key_in (block input),
//        out_valid/out_ready/ct_out (ciphertext output), busy (RUN or DONE).
// Byte 0 of every 128-bit word is bits [127:120].

// Rijndael forward S-box, a single combinational byte lookup.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Element 255 sits at the MSB, so table byte n lives at index 255-n (= ~n).
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[~a];
endmodule

// One AES encryption round: SubBytes, ShiftRows, MixColumns (skipped on round 10), AddRoundKey.
// Also advances the one-hot round counter; it parks on bit 10 so the counter stays one-hot.
module aesround (
  input  logic [127:0] round_in,
  input  logic [127:0] key_words,
  input  logic [10:0]  fin_counter_in,
  output logic [127:0] round_out,
  output logic [10:0]  fin_counter_out
);
  logic [127:0] sub_bytes;
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [7:0]   a0, a1, a2, a3;

  function automatic logic [7:0] byte_at(input logic [127:0] v, input int i);
    return v[127-8*i -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes_sbox u_sbox (
      .a (round_in[127-8*i -: 8]),
      .y (sub_bytes[127-8*i -: 8])
    );
  end

  always_comb begin
    shifted = '0;
    mixed   = '0;
    a0      = '0;
    a1      = '0;
    a2      = '0;
    a3      = '0;
    // Byte index 4*c+r is row r of column c; row r rotates left by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = byte_at(sub_bytes, 4*((c+r)%4) + r);
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = byte_at(shifted, 4*c);
      a1 = byte_at(shifted, 4*c+1);
      a2 = byte_at(shifted, 4*c+2);
      a3 = byte_at(shifted, 4*c+3);
      mixed[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      mixed[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      mixed[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      mixed[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    round_out = (fin_counter_in[10] ? shifted : mixed) ^ key_words;
  end

  assign fin_counter_out = fin_counter_in[10] ? fin_counter_in
                                              : {fin_counter_in[9:0], 1'b0};
endmodule

module aes128_iter_ctrl (
  input  logic         eph1,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct_out,
  output logic         busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [10:0]  ctr_q, ctr_d;

  logic [127:0] round_out;
  logic [10:0]  fin_counter_out;

  // Key expansion is shared between the accept cycle (expanding the cipher
  // key with rcon 01) and every RUN cycle (expanding the current round key).
  logic [127:0] ks_src;
  logic [7:0]   ks_rc;
  logic [31:0]  rot_w, sub_w, ks_t;
  logic [31:0]  w0n, w1n, w2n, w3n;
  logic [127:0] key_next;
  logic [7:0]   rcon_next;

  assign ks_src = (fsm_q == IDLE) ? key_in : rk_q;
  assign ks_rc  = (fsm_q == IDLE) ? 8'h01  : rcon_q;
  assign rot_w  = {ks_src[23:0], ks_src[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_ks_sb
    aes_sbox u_sbox (
      .a (rot_w[8*i +: 8]),
      .y (sub_w[8*i +: 8])
    );
  end

  assign ks_t     = sub_w ^ {ks_rc, 24'h0};
  assign w0n      = ks_src[127:96] ^ ks_t;
  assign w1n      = ks_src[95:64]  ^ w0n;
  assign w2n      = ks_src[63:32]  ^ w1n;
  assign w3n      = ks_src[31:0]   ^ w2n;
  assign key_next = {w0n, w1n, w2n, w3n};

  assign rcon_next = rcon_q[7] ? ({rcon_q[6:0], 1'b0} ^ 8'h1b) : {rcon_q[6:0], 1'b0};

  aesround u_round (
    .round_in        (state_q),
    .key_words       (rk_q),
    .fin_counter_in  (ctr_q),
    .round_out       (round_out),
    .fin_counter_out (fin_counter_out)
  );

  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      rcon_q  <= 8'h01;
      ctr_q   <= 11'b1;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      rcon_q  <= rcon_d;
      ctr_q   <= ctr_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    rcon_d  = rcon_q;
    ctr_d   = ctr_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = pt_in ^ key_in;
          rk_d    = key_next;
          rcon_d  = 8'h02;
          ctr_d   = 11'b000_0000_0010;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        // On round 10 the key/rcon updates are don't-care; the counter parks on bit 10.
        state_d = round_out;
        rk_d    = key_next;
        rcon_d  = rcon_next;
        ctr_d   = fin_counter_out;
        if (ctr_q[10]) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          ctr_d = 11'b1;
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q == RUN) || (fsm_q == DONE);
  assign ct_out    = (fsm_q == DONE) ? state_q : '0;
endmodule

// File: tb/tb_aes128_iter_ctrl.sv
module tb_aes128_iter_ctrl;
  logic         eph1 = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt_in;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct_out;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK1_B  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RK1_C  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

  aes128_iter_ctrl dut (
    .eph1      (eph1),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt_in     (pt_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ct_out    (ct_out),
    .busy      (busy)
  );

  always #5 eph1 = ~eph1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge eph1);
    #1;
  endtask

  // Present one block and return just after its accept edge (edge 0).
  task automatic accept(input logic [127:0] pt, input logic [127:0] key);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
    end
    pt_in    = pt;
    key_in   = key;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid, bounded.
  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 30) begin
      step();
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || ct_out !== 128'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b busy=%b ct_out=%h required 1 0 0 0",
               in_ready, out_valid, busy, ct_out);
    end
    n_cmp++;
    if (dut.ctr_q !== 11'b1 || dut.rcon_q !== 8'h01 || dut.state_q !== 128'h0 || dut.rk_q !== 128'h0) begin
      n_bad++;
      $display("FAIL reset_regs: ctr_q=%b rcon_q=%h state_q=%h rk_q=%h required 1 01 0 0",
               dut.ctr_q, dut.rcon_q, dut.state_q, dut.rk_q);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_fips_b();
    accept(PT_B, KEY_B);
    n_cmp++;
    if (dut.rk_q !== RK1_B) begin
      n_bad++;
      $display("FAIL b_rk1: rk_q=%h required %h", dut.rk_q, RK1_B);
    end
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b_run_flags: busy=%b in_ready=%b out_valid=%b required 1 0 0", busy, in_ready, out_valid);
    end
    repeat (9) step();
    n_cmp++;
    if (dut.rk_q !== RK10_B) begin
      n_bad++;
      $display("FAIL b_rk10: rk_q=%h required %h", dut.rk_q, RK10_B);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b_early_valid: out_valid=%b after edge 9 required 0", out_valid);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || ct_out !== CT_B) begin
      n_bad++;
      $display("FAIL b_ct: out_valid=%b ct_out=%h required 1 %h", out_valid, ct_out, CT_B);
    end
    release_out();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || ct_out !== 128'h0) begin
      n_bad++;
      $display("FAIL b_release: in_ready=%b out_valid=%b busy=%b ct_out=%h required 1 0 0 0",
               in_ready, out_valid, busy, ct_out);
    end
  endtask

  task automatic test_fips_c1();
    logic [10:0] exp_ctr;
    accept(PT_C, KEY_C);
    n_cmp++;
    if (dut.rk_q !== RK1_C) begin
      n_bad++;
      $display("FAIL c1_rk1: rk_q=%h required %h", dut.rk_q, RK1_C);
    end
    for (int k = 0; k < 10; k++) begin
      exp_ctr = 11'd1 << (k + 1);
      n_cmp++;
      if (dut.ctr_q !== exp_ctr || out_valid !== 1'b0 || ct_out !== 128'h0) begin
        n_bad++;
        $display("FAIL c1_ctr_edge%0d: ctr_q=%b out_valid=%b ct_out=%h required %b 0 0",
                 k, dut.ctr_q, out_valid, ct_out, exp_ctr);
      end
      step();
    end
    n_cmp++;
    if (out_valid !== 1'b1 || ct_out !== CT_C || dut.ctr_q !== 11'b100_0000_0000) begin
      n_bad++;
      $display("FAIL c1_ct: out_valid=%b ct_out=%h ctr_q=%b required 1 %h 10000000000",
               out_valid, ct_out, dut.ctr_q, CT_C);
    end
    release_out();
    n_cmp++;
    if (dut.ctr_q !== 11'b1) begin
      n_bad++;
      $display("FAIL c1_ctr_release: ctr_q=%b required 1", dut.ctr_q);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    accept(PT_B, KEY_B);
    wait_out(lat);
    n_cmp++;
    if (lat !== 10) begin
      n_bad++;
      $display("FAIL bp_latency: %0d cycles required 10", lat);
    end
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      pt_in    = PT_C;
      key_in   = KEY_C;
      step();
      n_cmp++;
      if (ct_out !== CT_B || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_hold%0d: ct_out=%h in_ready=%b out_valid=%b required %h 0 1",
                 i, ct_out, in_ready, out_valid, CT_B);
      end
    end
    in_valid = 1'b0;
    release_out();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0 || dut.ctr_q !== 11'b1) begin
      n_bad++;
      $display("FAIL bp_idle: busy=%b ctr_q=%b required 0 1", busy, dut.ctr_q);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pts [2];
    logic [127:0] keys [2];
    logic [127:0] got_ct [2];
    int acc_edge [2];
    int sent = 0;
    int got = 0;
    int cyc = 0;
    pts[0] = PT_B;  keys[0] = KEY_B;
    pts[1] = PT_C;  keys[1] = KEY_C;
    got_ct[0] = '0; got_ct[1] = '0;
    acc_edge[0] = 0; acc_edge[1] = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && got < 2; i++) begin
      if (out_valid === 1'b1) begin
        got_ct[got] = ct_out;
        got++;
      end
      if (in_ready === 1'b1 && sent < 2) begin
        pt_in          = pts[sent];
        key_in         = keys[sent];
        in_valid       = 1'b1;
        acc_edge[sent] = cyc + 1;
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (got !== 2 || got_ct[0] !== CT_B) begin
      n_bad++;
      $display("FAIL b2b_first: blocks=%0d ct=%h required 2 %h", got, got_ct[0], CT_B);
    end
    n_cmp++;
    if (got_ct[1] !== CT_C) begin
      n_bad++;
      $display("FAIL b2b_second: ct=%h required %h", got_ct[1], CT_C);
    end
    n_cmp++;
    if (acc_edge[1] - acc_edge[0] !== 12) begin
      n_bad++;
      $display("FAIL b2b_interval: %0d cycles required 12", acc_edge[1] - acc_edge[0]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int saw_valid = 0;
    accept(PT_C, KEY_C);
    repeat (4) step();
    n_cmp++;
    if (dut.ctr_q !== 11'b000_0010_0000) begin
      n_bad++;
      $display("FAIL rst_round5: ctr_q=%b required 00000100000", dut.ctr_q);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || dut.ctr_q !== 11'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid: busy=%b ctr_q=%b out_valid=%b in_ready=%b required 0 1 0 1",
               busy, dut.ctr_q, out_valid, in_ready);
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid !== 1'b0) saw_valid++;
    end
    n_cmp++;
    if (saw_valid !== 0) begin
      n_bad++;
      $display("FAIL rst_no_valid: out_valid high in %0d cycles required 0", saw_valid);
    end
    accept(PT_B, KEY_B);
    wait_out(lat);
    n_cmp++;
    if (lat !== 10 || ct_out !== CT_B) begin
      n_bad++;
      $display("FAIL rst_rerun: latency=%0d ct_out=%h required 10 %h", lat, ct_out, CT_B);
    end
    release_out();
  endtask

  task automatic test_input_noise();
    int lat = 0;
    accept(PT_C, KEY_C);
    while (out_valid !== 1'b1 && lat < 30) begin
      in_valid = 1'($urandom_range(0, 1));
      pt_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
      key_in   = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      lat++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (lat !== 10 || ct_out !== CT_C) begin
      n_bad++;
      $display("FAIL noise_ct: latency=%0d ct_out=%h required 10 %h", lat, ct_out, CT_C);
    end
    release_out();
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL noise_release: in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pt_in     = '0;
    key_in    = '0;
    #2;
    test_reset();
    test_fips_b();
    test_fips_c1();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_input_noise();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
